// File: rtl/cva6_hpdcache_req_arbiter.sv
// Round-robin arbiter sharing one HPDcache request/response port among NREQ requesters.
// Holds a grant under backpressure, stamps the SID and routes responses back by SID.
package cva6_hpdcache_req_arbiter_pkg;
  localparam int unsigned SID_W = 4;

  typedef struct packed {
    logic [31:0]      addr;
    logic [31:0]      wdata;
    logic [3:0]       op;
    logic [3:0]       be;
    logic             need_rsp;
    logic [SID_W-1:0] sid;
  } hpdcache_req_t;

  typedef struct packed {
    logic [31:0]      rdata;
    logic [SID_W-1:0] sid;
    logic             error;
  } hpdcache_rsp_t;
endpackage

module cva6_hpdcache_req_arbiter
  import cva6_hpdcache_req_arbiter_pkg::*;
#(
  parameter int unsigned NREQ     = 3,
  parameter int unsigned MAX_PEND = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic          [NREQ-1:0]       req_valid_i,
  output logic          [NREQ-1:0]       req_ready_o,
  input  hpdcache_req_t [NREQ-1:0]       req_i,
  output logic          [NREQ-1:0]       rsp_valid_o,
  output hpdcache_rsp_t                  rsp_o,
  output logic                           dcache_req_valid_o,
  input  logic                           dcache_req_ready_i,
  output hpdcache_req_t                  dcache_req_o,
  input  logic                           dcache_rsp_valid_i,
  input  hpdcache_rsp_t                  dcache_rsp_i,
  output logic                           idle_o,
  output logic                           err_o
);

  localparam int unsigned CNT_W = $clog2(MAX_PEND + 1);
  localparam int unsigned IDX_W = $clog2(NREQ);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PEND);

  logic [IDX_W-1:0] rr_q;
  logic [IDX_W-1:0] sel_q;
  logic             lock_q;
  logic             err_q;
  logic [CNT_W-1:0] pend_q [NREQ];

  logic [NREQ-1:0]  eligible;
  logic [NREQ-1:0]  inc;
  logic [NREQ-1:0]  dec;
  logic [NREQ-1:0]  underflow;
  logic             found;
  logic [IDX_W-1:0] scan_gnt;
  logic [IDX_W-1:0] gnt;
  logic             gnt_valid;
  logic             hs;
  logic             bad_sid;
  logic             pend_zero;
  int unsigned      idx;

  // First eligible requester at or after rr_q, wrapping modulo NREQ.
  always_comb begin
    eligible = '0;
    found    = 1'b0;
    scan_gnt = '0;
    idx      = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      eligible[i] = req_valid_i[i] && (!req_i[i].need_rsp || pend_q[i] < MAX_CNT);
    end
    for (int unsigned off = 0; off < NREQ; off++) begin
      idx = (32'(rr_q) + off) % NREQ;
      if (!found && eligible[idx]) begin
        found    = 1'b1;
        scan_gnt = IDX_W'(idx);
      end
    end
  end

  // A locked grant bypasses eligibility so an offered request is never withdrawn.
  always_comb begin
    gnt          = lock_q ? sel_q : scan_gnt;
    gnt_valid    = rst_ni && (lock_q || found);
    hs           = gnt_valid && dcache_req_ready_i;
    req_ready_o  = '0;
    if (gnt_valid) req_ready_o[gnt] = dcache_req_ready_i;
    dcache_req_valid_o = gnt_valid;
    dcache_req_o       = req_i[gnt];
    dcache_req_o.sid   = SID_W'(gnt);
  end

  always_comb begin
    rsp_o       = dcache_rsp_i;
    rsp_valid_o = '0;
    inc         = '0;
    dec         = '0;
    underflow   = '0;
    pend_zero   = 1'b1;
    bad_sid     = dcache_rsp_valid_i && (dcache_rsp_i.sid >= SID_W'(NREQ));
    for (int unsigned i = 0; i < NREQ; i++) begin
      dec[i]         = dcache_rsp_valid_i && (dcache_rsp_i.sid == SID_W'(i));
      rsp_valid_o[i] = rst_ni && dec[i];
      inc[i]         = hs && (gnt == IDX_W'(i)) && req_i[i].need_rsp;
      underflow[i]   = dec[i] && !inc[i] && (pend_q[i] == '0);
      if (pend_q[i] != '0) pend_zero = 1'b0;
    end
  end

  assign idle_o = (req_valid_i == '0) && pend_zero;
  assign err_o  = err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q   <= '0;
      sel_q  <= '0;
      lock_q <= 1'b0;
      err_q  <= 1'b0;
      for (int unsigned i = 0; i < NREQ; i++) pend_q[i] <= '0;
    end else begin
      if (hs) rr_q <= IDX_W'((32'(gnt) + 32'd1) % NREQ);
      if (gnt_valid && !dcache_req_ready_i) begin
        lock_q <= 1'b1;
        sel_q  <= gnt;
      end else if (hs) begin
        lock_q <= 1'b0;
      end
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (inc[i] && !dec[i]) pend_q[i] <= pend_q[i] + CNT_W'(1);
        else if (dec[i] && !inc[i] && pend_q[i] != '0) pend_q[i] <= pend_q[i] - CNT_W'(1);
      end
      if (bad_sid || (underflow != '0)) err_q <= 1'b1;
    end
  end

  // A locked requester must keep its request asserted until accepted.
  a_hold_valid: assert property (@(posedge clk_i) disable iff (!rst_ni)
    lock_q |-> req_valid_i[sel_q]);

endmodule
